task_out_packetizer: RTL and testbench

Parametrised output stage between a task core and the task manager. It buffers result words of IN_WIDTH bits in an internal FIFO and serialises them into OUT_WIDTH-bit beats. It emits packets of PKT_WORDS words. A task's final short packet is flushed on i_input_last. Each packet carries its size in bytes and a last-beat marker, and the stage supports manager backpressure.

---
 rtl/task_out_packetizer.sv | 173 +++++++++++++++++
 tb/tb_task_out_packetizer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_out_packetizer.sv
// Buffers task result words in a FIFO and serialises them into OUT_WIDTH beats,
// grouped into packets of up to PKT_WORDS words with byte count and last-beat marker.
module task_out_packetizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int PKT_WORDS = 16,
    parameter int DEPTH     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [IN_WIDTH-1:0]      i_data,
    input  logic                     i_data_valid,
    input  logic                     i_input_last,
    output logic                     o_in_ready,
    input  logic                     i_tmanager_ready,
    output logic                     o_tanswer_ready,
    output logic [OUT_WIDTH-1:0]     o_tdata,
    output logic                     o_tanswer_data_last,
    output logic [11:0]              o_packet_size_in_bytes,
    output logic                     o_busy,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int R  = IN_WIDTH / OUT_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int NW = $clog2(PKT_WORDS + 1);

    localparam logic [LW-1:0] LAST_LANE  = LW'(R - 1);
    localparam logic [AW:0]   PKT_LVL    = (AW + 1)'(PKT_WORDS);
    localparam logic [AW:0]   DEPTH_LVL  = (AW + 1)'(DEPTH);
    localparam logic [NW-1:0] PKT_N      = NW'(PKT_WORDS);
    localparam logic [11:0]   WORD_BYTES = 12'(IN_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_DONE} state_t;
    state_t state_q, state_d;

    logic [IN_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]         count;
    logic                full, in_ready, wr_en;
    logic                last_pending, overflow_q;

    logic [IN_WIDTH-1:0] word_q;
    logic [LW-1:0]       lane;
    logic [NW-1:0]       words_rem;
    logic                busy_q;
    logic [11:0]         size_q;

    logic                latch_n, load_first, beat_fire, word_done, pkt_end, clear_last, tlast;
    logic [NW-1:0]       n_val;

    assign full        = (count == DEPTH_LVL);
    assign in_ready    = !full && !last_pending;
    assign wr_en       = i_data_valid && in_ready;
    assign rd_ptr_next = rd_ptr + 1'b1;
    assign tlast       = (words_rem == NW'(1)) && (lane == LAST_LANE);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        latch_n    = 1'b0;
        n_val      = '0;
        load_first = 1'b0;
        beat_fire  = 1'b0;
        word_done  = 1'b0;
        pkt_end    = 1'b0;
        clear_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count >= PKT_LVL) begin
                    state_d = S_START;
                    latch_n = 1'b1;
                    n_val   = PKT_N;
                end else if (last_pending && count != '0) begin
                    state_d = S_START;
                    latch_n = 1'b1;
                    n_val   = NW'(count);
                end
            end
            S_START: begin
                load_first = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (i_tmanager_ready) begin
                    beat_fire = 1'b1;
                    word_done = (lane == LAST_LANE);
                    if (tlast) begin
                        pkt_end = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                clear_last = last_pending && (count == '0);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A word keeps its FIFO slot until its final lane leaves, so o_level counts unsent words.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)     wr_ptr <= wr_ptr + 1'b1;
            if (word_done) rd_ptr <= rd_ptr_next;
            count <= count + (AW + 1)'(wr_en) - (AW + 1)'(word_done);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_pending <= 1'b0;
            overflow_q   <= 1'b0;
            word_q       <= '0;
            lane         <= '0;
            words_rem    <= '0;
            busy_q       <= 1'b0;
            size_q       <= '0;
        end else begin
            if (wr_en && i_input_last) last_pending <= 1'b1;
            else if (clear_last)       last_pending <= 1'b0;
            if (i_data_valid && full)  overflow_q   <= 1'b1;
            if (latch_n) words_rem <= n_val;
            if (load_first) begin
                word_q <= mem[rd_ptr];
                lane   <= '0;
                busy_q <= 1'b1;
                size_q <= 12'(words_rem) * WORD_BYTES;
            end
            if (beat_fire) begin
                if (word_done) begin
                    lane      <= '0;
                    words_rem <= words_rem - 1'b1;
                    word_q    <= pkt_end ? '0 : mem[rd_ptr_next];
                end else begin
                    lane   <= lane + 1'b1;
                    word_q <= word_q >> OUT_WIDTH;
                end
            end
            if (pkt_end) begin
                busy_q <= 1'b0;
                size_q <= '0;
            end
        end
    end

    assign o_in_ready             = in_ready;
    assign o_tanswer_ready        = (state_q == S_SEND);
    assign o_tdata                = word_q[OUT_WIDTH-1:0];
    assign o_tanswer_data_last    = (state_q == S_SEND) && tlast;
    assign o_packet_size_in_bytes = size_q;
    assign o_busy                 = busy_q;
    assign o_full                 = full;
    assign o_level                = count;
    assign o_overflow             = overflow_q;

endmodule

// File: tb/tb_task_out_packetizer.sv
// Bench for task_out_packetizer: a packet-level model chunks each task's words
// into expected beats; a negedge monitor compares every transferred beat.
module tb_task_out_packetizer;

    localparam int IN_WIDTH  = 32;
    localparam int OUT_WIDTH = 8;
    localparam int PKT_WORDS = 16;
    localparam int DEPTH     = 64;
    localparam int R         = IN_WIDTH / OUT_WIDTH;
    localparam int LVLW      = $clog2(DEPTH) + 1;
    localparam int EW        = 12 + 1 + OUT_WIDTH;

    logic                 i_clk, i_rst;
    logic [IN_WIDTH-1:0]  i_data;
    logic                 i_data_valid, i_input_last, i_tmanager_ready;
    logic                 o_in_ready, o_tanswer_ready, o_tanswer_data_last;
    logic [OUT_WIDTH-1:0] o_tdata;
    logic [11:0]          o_packet_size_in_bytes;
    logic                 o_busy, o_full, o_overflow;
    logic [LVLW-1:0]      o_level;

    task_out_packetizer #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .PKT_WORDS(PKT_WORDS), .DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_data(i_data), .i_data_valid(i_data_valid), .i_input_last(i_input_last),
        .o_in_ready(o_in_ready), .i_tmanager_ready(i_tmanager_ready),
        .o_tanswer_ready(o_tanswer_ready), .o_tdata(o_tdata),
        .o_tanswer_data_last(o_tanswer_data_last),
        .o_packet_size_in_bytes(o_packet_size_in_bytes),
        .o_busy(o_busy), .o_full(o_full), .o_level(o_level), .o_overflow(o_overflow)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int errors = 0;
    int beat_count = 0;
    int mgr_mode = 1;  // 0 never ready, 1 always ready, 2 random
    logic [EW-1:0]       exp_q[$];
    logic [IN_WIDTH-1:0] pkt_buf[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_flush();
        int n;
        logic [11:0] sz;
        n  = pkt_buf.size();
        sz = 12'(n * IN_WIDTH / 8);
        for (int w = 0; w < n; w++) begin
            for (int l = 0; l < R; l++) begin
                logic [OUT_WIDTH-1:0] b;
                logic lst;
                b   = OUT_WIDTH'(pkt_buf[w] >> (l * OUT_WIDTH));
                lst = (w == n - 1) && (l == R - 1);
                exp_q.push_back({sz, lst, b});
            end
        end
        pkt_buf.delete();
    endfunction

    function automatic void model_word(input logic [IN_WIDTH-1:0] d, input logic last);
        pkt_buf.push_back(d);
        if (pkt_buf.size() == PKT_WORDS || last) model_flush();
    endfunction

    function automatic logic [IN_WIDTH-1:0] word_k(input int k);
        logic [IN_WIDTH-1:0] w;
        for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(4 * k + j);
        return w;
    endfunction

    // ---------------- manager driver ----------------
    initial begin
        i_tmanager_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (mgr_mode)
                0:       i_tmanager_ready = 1'b0;
                1:       i_tmanager_ready = 1'b1;
                default: i_tmanager_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0]        e;
        logic [OUT_WIDTH-1:0] held;
        logic                 hold_v;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v && o_tanswer_ready) check("tdata_hold", 32'(o_tdata), 32'(held));
                if (o_tanswer_ready && i_tmanager_ready) begin
                    beat_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected: got beat 0x%0h, want no beat", o_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(o_tdata), 32'(e[OUT_WIDTH-1:0]));
                        check("beat_last", 32'(o_tanswer_data_last), 32'(e[OUT_WIDTH]));
                        check("beat_size", 32'(o_packet_size_in_bytes), 32'(e[EW-1:OUT_WIDTH+1]));
                    end
                    hold_v = 1'b0;
                end else if (o_tanswer_ready) begin
                    hold_v = 1'b1;
                    held   = o_tdata;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_word(input logic [IN_WIDTH-1:0] d, input logic last, input logic exp_acc);
        i_data       = d;
        i_data_valid = 1'b1;
        i_input_last = last;
        check("in_ready", 32'(o_in_ready), 32'(exp_acc));
        if (exp_acc) model_word(d, last);
        tick();
        i_data_valid = 1'b0;
        i_input_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && o_in_ready && !o_busy && !o_tanswer_ready) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL idle_timeout: got %0d beats still expected, want 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_tanswer_ready", 32'(o_tanswer_ready), 32'd0);
        check("rst_tdata", 32'(o_tdata), 32'd0);
        check("rst_data_last", 32'(o_tanswer_data_last), 32'd0);
        check("rst_size", 32'(o_packet_size_in_bytes), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len, base, n;
        i_rst        = 1'b1;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_input_last = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        i_rst = 1'b0;
        tick();

        // Full 16-word packet, latency and ordering
        for (int k = 0; k < 16; k++) write_word(word_k(k), 1'b0, 1'b1);
        check("lat_cycle_t", 32'(o_tanswer_ready), 32'd0);
        tick();
        check("lat_start_valid", 32'(o_tanswer_ready), 32'd0);
        check("lat_start_busy", 32'(o_busy), 32'd0);
        tick();
        check("lat_send_valid", 32'(o_tanswer_ready), 32'd1);
        check("lat_send_size", 32'(o_packet_size_in_bytes), 32'd64);
        check("lat_send_busy", 32'(o_busy), 32'd1);
        wait_idle();
        check("t1_busy_clear", 32'(o_busy), 32'd0);

        // Short task flushed by the last marker
        for (int k = 0; k < 5; k++) write_word($urandom, k == 4, 1'b1);
        check("t2_in_ready_blocked", 32'(o_in_ready), 32'd0);
        wait_idle();
        check("t2_in_ready_back", 32'(o_in_ready), 32'd1);

        // 37-word task: 64 + 64 + 20 bytes
        for (int k = 0; k < 37; k++) write_word(word_k(k), k == 36, 1'b1);
        wait_idle();

        // Random backpressure on a full packet
        mgr_mode = 2;
        for (int k = 0; k < 16; k++) write_word($urandom, 1'b0, 1'b1);
        wait_idle();

        // Random tasks with random gaps and backpressure
        repeat (6) begin
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                write_word($urandom, k == len - 1, 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle();
        end

        // Overflow with a stalled manager
        mgr_mode = 0;
        tick();
        tick();
        for (int k = 0; k < 70; k++) begin
            write_word($urandom, 1'b0, k < DEPTH);
            if (k == DEPTH - 1) begin
                check("ovf_full", 32'(o_full), 32'd1);
                check("ovf_level", 32'(o_level), 32'(DEPTH));
                check("ovf_not_yet", 32'(o_overflow), 32'd0);
            end
            if (k == DEPTH) check("ovf_set", 32'(o_overflow), 32'd1);
        end
        mgr_mode = 1;
        wait_idle();
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Reset in the middle of a packet
        base = beat_count;
        for (int k = 0; k < 16; k++) write_word(word_k(k + 40), 1'b0, 1'b1);
        n = 0;
        while (beat_count < base + 10 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL mid_reset_wait: got %0d beats, want %0d", beat_count - base, 10);
        end
        i_rst = 1'b1;
        exp_q.delete();
        pkt_buf.delete();
        tick();
        check_reset_outputs();
        i_rst = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) write_word(word_k(k + 20), 1'b0, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
